mem_port_arbiter: RTL and testbench

Shares one single-port, 1-cycle-latency data RAM between three requesters: core deferred writes, core fast-port data reads, and the I$ refill engine. The refill engine runs 8-beat line bursts. The block sits between VioletCore's sysbus fast and ic_refill ports and the data store. Arbitration is per cycle: deferred write first, then data read, then refill beat.

---
 rtl/mem_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port data RAM (1-cycle read latency) between three
// requesters, with a fixed priority that is resolved every cycle:
//   1. deferred core writes (wr_*), which can never be stalled
//   2. core fast-port data reads (fast_*)
//   3. I$ refill beats issued by a small IDLE/BURST/DONE FSM (ic_req_*/refill_*)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fast_valid/fast_addr  data read request (byte address)
//   fast_ready/fast_data  one-cycle pulse with read data, cycle after grant
//   wr_valid/addr/data/mask  deferred write with byte-lane enables
//   ic_req_valid/addr     refill request, held until refill_ready
//   refill_valid/addr/data  one refill beat per asserted cycle
//   refill_ready          line complete, held until ic_req_valid drops
//   ram_en/we/addr/wdata  RAM command (word address), ram_rdata return data
//
// Optional feature: define MEM_ARB_PERF_EN to add the saturating counters
// refill_stall_cnt and read_conflict_cnt as extra output ports.

module mem_port_arbiter #(
    parameter int          LINE_WORDS = 8,
    parameter int          WORD_AW    = 16,
    parameter logic [3:0]  IO_NIBBLE  = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fast_valid,
    input  logic [31:0]        fast_addr,
    output logic               fast_ready,
    output logic [31:0]        fast_data,
    input  logic               wr_valid,
    input  logic [31:0]        wr_addr,
    input  logic [31:0]        wr_data,
    input  logic [3:0]         wr_mask,
    input  logic               ic_req_valid,
    input  logic [31:0]        ic_req_addr,
    output logic               refill_valid,
    output logic [31:0]        refill_addr,
    output logic [31:0]        refill_data,
    output logic               refill_ready,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]        refill_stall_cnt,
    output logic [31:0]        read_conflict_cnt,
`endif
    output logic               ram_en,
    output logic [3:0]         ram_we,
    output logic [WORD_AW-1:0] ram_addr,
    output logic [31:0]        ram_wdata,
    input  logic [31:0]        ram_rdata
);

    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam logic [31:0]       OFF_MASK  = (32'd1 << OFF_W) - 32'd1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic [31:0]       base_reg, base_next;
    logic              issued_all_reg, issued_all_next;
    logic              rd_pend_reg;
    logic              rf_pend_reg;
    logic [31:0]       rf_addr_reg;

    logic              wr_gnt, rd_gnt, rf_gnt;
    logic              rf_want;
    logic [31:0]       beat_addr;

    // Grants are forced low while reset is asserted so the RAM command
    // outputs drop to zero immediately, not at the next clock edge.
    assign rf_want = (state_reg == BURST) && !issued_all_reg;
    assign wr_gnt  = rst_n && wr_valid;
    assign rd_gnt  = rst_n && !wr_valid && fast_valid;
    assign rf_gnt  = rst_n && !wr_valid && !fast_valid && rf_want;

    // base is line-aligned, so adding the beat offset never carries out of
    // the line; the 32-bit add itself wraps modulo 2^32.
    assign beat_addr = base_reg + (32'(beat_reg) << 2);

    // RAM command mux
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = 32'd0;
        if (wr_gnt) begin
            // A zero mask still consumes the slot.
            ram_en    = 1'b1;
            ram_we    = wr_mask;
            ram_addr  = wr_addr[WORD_AW+1:2];
            ram_wdata = wr_data;
        end else if (rd_gnt) begin
            ram_en   = 1'b1;
            ram_addr = fast_addr[WORD_AW+1:2];
        end else if (rf_gnt) begin
            ram_en   = 1'b1;
            ram_addr = beat_addr[WORD_AW+1:2];
        end
    end

    // Refill FSM: next state
    always_comb begin
        state_next      = state_reg;
        beat_next       = beat_reg;
        base_next       = base_reg;
        issued_all_next = issued_all_reg;
        case (state_reg)
            IDLE: begin
                if (ic_req_valid) begin
                    base_next       = ic_req_addr & ~OFF_MASK;
                    beat_next       = '0;
                    issued_all_next = 1'b0;
                    state_next      = BURST;
                end
            end
            BURST: begin
                if (rf_gnt) begin
                    beat_next = beat_reg + BEAT_ONE;
                    if (beat_reg == LAST_BEAT) begin
                        issued_all_next = 1'b1;
                    end
                end
                // Leave once the final beat is actually on refill_* outputs,
                // so refill_ready follows the last beat by one cycle.
                if (issued_all_reg && rf_pend_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!ic_req_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            beat_reg       <= '0;
            base_reg       <= 32'd0;
            issued_all_reg <= 1'b0;
            rd_pend_reg    <= 1'b0;
            rf_pend_reg    <= 1'b0;
            rf_addr_reg    <= 32'd0;
        end else begin
            state_reg      <= state_next;
            beat_reg       <= beat_next;
            base_reg       <= base_next;
            issued_all_reg <= issued_all_next;
            // IO-region reads take the RAM slot but never complete here.
            rd_pend_reg    <= rd_gnt && (fast_addr[31:28] != IO_NIBBLE);
            rf_pend_reg    <= rf_gnt;
            if (rf_gnt) begin
                rf_addr_reg <= beat_addr;
            end
        end
    end

    assign fast_ready   = rd_pend_reg;
    assign fast_data    = rd_pend_reg ? ram_rdata : 32'd0;
    assign refill_valid = rf_pend_reg;
    assign refill_addr  = rf_pend_reg ? rf_addr_reg : 32'd0;
    assign refill_data  = rf_pend_reg ? ram_rdata : 32'd0;
    assign refill_ready = (state_reg == DONE);

`ifdef MEM_ARB_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] conflict_cnt_reg;

    // Only cycles where a beat is still waiting to issue count as stalls;
    // the cycle presenting the final beat has nothing left to request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg    <= 32'd0;
            conflict_cnt_reg <= 32'd0;
        end else begin
            if (rf_want && !rf_gnt && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (fast_valid && wr_valid && (conflict_cnt_reg != 32'hFFFF_FFFF)) begin
                conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
            end
        end
    end

    assign refill_stall_cnt  = stall_cnt_reg;
    assign read_conflict_cnt = conflict_cnt_reg;
`endif

    // Address bits outside the RAM index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr, fast_addr, beat_addr};

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        fast_valid;
    logic [31:0] fast_addr;
    logic        fast_ready;
    logic [31:0] fast_data;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        refill_valid;
    logic [31:0] refill_addr;
    logic [31:0] refill_data;
    logic        refill_ready;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] refill_stall_cnt;
    logic [31:0] read_conflict_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    logic [31:0] mem [0:65535];
    logic [151:0] outs;

    assign outs = {fast_ready, fast_data, refill_valid, refill_addr, refill_data,
                   refill_ready, ram_en, ram_we, ram_addr, ram_wdata};

    mem_port_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fast_valid        (fast_valid),
        .fast_addr         (fast_addr),
        .fast_ready        (fast_ready),
        .fast_data         (fast_data),
        .wr_valid          (wr_valid),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .wr_mask           (wr_mask),
        .ic_req_valid      (ic_req_valid),
        .ic_req_addr       (ic_req_addr),
        .refill_valid      (refill_valid),
        .refill_addr       (refill_addr),
        .refill_data       (refill_data),
        .refill_ready      (refill_ready),
`ifdef MEM_ARB_PERF_EN
        .refill_stall_cnt  (refill_stall_cnt),
        .read_conflict_cnt (read_conflict_cnt),
`endif
        .ram_en            (ram_en),
        .ram_we            (ram_we),
        .ram_addr          (ram_addr),
        .ram_wdata         (ram_wdata),
        .ram_rdata         (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM, 1-cycle read latency, byte write enables
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) tick;
        #1;
        checks++;
        if (outs !== 152'd0) begin
            $display("FAIL reset_outputs: got %h expected 0", outs);
            fails++;
        end
        rst_n = 1'b1;
        tick;
        checks++;
        if ({fast_ready, refill_valid, refill_ready} !== 3'b000) begin
            $display("FAIL post_reset_idle: got %b expected 000", {fast_ready, refill_valid, refill_ready});
            fails++;
        end
        $display("reset: outputs %h after release", {fast_ready, refill_valid, refill_ready});
    endtask

    task automatic test_read;
        fast_valid = 1'b1;
        fast_addr  = 32'h0000_0100;
        #1;
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 4'h0, 16'h0040}) begin
            $display("FAIL read_ram_cmd: got %h expected %h", {ram_en, ram_we, ram_addr}, {1'b1, 4'h0, 16'h0040});
            fails++;
        end
        tick;
        fast_valid = 1'b0;
        checks++;
        if ({fast_ready, fast_data} !== {1'b1, 32'hDEADBEEF}) begin
            $display("FAIL read_data: got %b/%h expected 1/deadbeef", fast_ready, fast_data);
            fails++;
        end
        $display("read 0x100: ready=%b data=%h", fast_ready, fast_data);
        tick;
        checks++;
        if (fast_ready !== 1'b0) begin
            $display("FAIL read_pulse: got %b expected 0", fast_ready);
            fails++;
        end
    endtask

    task automatic test_write;
        wr_valid = 1'b1;
        wr_addr  = 32'h0000_0100;
        wr_data  = 32'h1122_3344;
        wr_mask  = 4'b0101;
        #1;
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 4'b0101, 16'h0040, 32'h11223344}) begin
            $display("FAIL write_ram_cmd: got %h expected %h", {ram_en, ram_we, ram_addr, ram_wdata},
                     {1'b1, 4'b0101, 16'h0040, 32'h11223344});
            fails++;
        end
        tick;
        wr_valid   = 1'b0;
        fast_valid = 1'b1;
        fast_addr  = 32'h0000_0100;
        tick;
        fast_valid = 1'b0;
        checks++;
        if ({fast_ready, fast_data} !== {1'b1, 32'hDE22BE44}) begin
            $display("FAIL write_mask_merge: got %b/%h expected 1/de22be44", fast_ready, fast_data);
            fails++;
        end
        $display("write 0x100 mask 0101 then read: data=%h", fast_data);
    endtask

    task automatic test_conflict;
        wr_valid   = 1'b1;
        wr_addr    = 32'h0000_0200;
        wr_data    = 32'hCAFE_F00D;
        wr_mask    = 4'hF;
        fast_valid = 1'b1;
        fast_addr  = 32'h0000_0200;
        tick;
        wr_valid = 1'b0;
        checks++;
        if (fast_ready !== 1'b0) begin
            $display("FAIL conflict_lost: got %b expected 0", fast_ready);
            fails++;
        end
        tick;
        fast_valid = 1'b0;
        checks++;
        if ({fast_ready, fast_data} !== {1'b1, 32'hCAFEF00D}) begin
            $display("FAIL conflict_retry: got %b/%h expected 1/cafef00d", fast_ready, fast_data);
            fails++;
        end
        $display("conflict 0x200: retry ready=%b data=%h", fast_ready, fast_data);
`ifdef MEM_ARB_PERF_EN
        checks++;
        if (read_conflict_cnt !== 32'd1) begin
            $display("FAIL conflict_cnt: got %0d expected 1", read_conflict_cnt);
            fails++;
        end
`endif
    endtask

    task automatic test_mask_zero;
        wr_valid   = 1'b1;
        wr_addr    = 32'h0000_0300;
        wr_data    = 32'hFFFF_FFFF;
        wr_mask    = 4'h0;
        fast_valid = 1'b1;
        fast_addr  = 32'h0000_0100;
        #1;
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 4'h0, 16'h00C0}) begin
            $display("FAIL mask0_slot: got %h expected %h", {ram_en, ram_we, ram_addr}, {1'b1, 4'h0, 16'h00C0});
            fails++;
        end
        tick;
        wr_valid = 1'b0;
        checks++;
        if (fast_ready !== 1'b0) begin
            $display("FAIL mask0_read_lost: got %b expected 0", fast_ready);
            fails++;
        end
        tick;
        fast_valid = 1'b0;
        checks++;
        if ({fast_ready, fast_data} !== {1'b1, 32'hDE22BE44}) begin
            $display("FAIL mask0_retry: got %b/%h expected 1/de22be44", fast_ready, fast_data);
            fails++;
        end
        $display("mask0 write: retry read data=%h", fast_data);
    endtask

    task automatic test_io_read;
        fast_valid = 1'b1;
        fast_addr  = 32'hF000_0010;
        #1;
        checks++;
        if (ram_en !== 1'b1) begin
            $display("FAIL io_slot: got %b expected 1", ram_en);
            fails++;
        end
        for (int k = 0; k < 2; k++) begin
            tick;
            checks++;
            if (fast_ready !== 1'b0) begin
                $display("FAIL io_no_ack: got %b expected 0", fast_ready);
                fails++;
            end
        end
        fast_valid = 1'b0;
        $display("io read 0xf0000010: ready=%b", fast_ready);
        tick;
    endtask

    task automatic test_refill;
        int nb = 0;
        int ready_k = -1;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_1234;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (refill_valid) begin
                checks++;
                if ({refill_addr, refill_data} !== {32'h1220 + 32'(4*nb), 32'hA500_0000 + 32'(nb)} || k != nb + 2) begin
                    $display("FAIL refill_beat%0d: got %h/%h at cycle %0d expected %h/%h at cycle %0d", nb,
                             refill_addr, refill_data, k, 32'h1220 + 32'(4*nb), 32'hA500_0000 + 32'(nb), nb + 2);
                    fails++;
                end
                $display("refill beat %0d: addr=%h data=%h cycle=%0d", nb, refill_addr, refill_data, k);
                nb++;
            end
            if (refill_ready) begin
                ready_k = k;
                break;
            end
        end
        checks++;
        if (nb != 8 || ready_k != 10) begin
            $display("FAIL refill_complete: got %0d beats ready at %0d expected 8 beats ready at 10", nb, ready_k);
            fails++;
        end
        ic_req_valid = 1'b0;
        tick;
        checks++;
        if ({refill_ready, refill_valid} !== 2'b00) begin
            $display("FAIL refill_release: got %b expected 00", {refill_ready, refill_valid});
            fails++;
        end
    endtask

    task automatic test_refill_stall;
        int nb = 0;
        int ready_k = -1;
        logic exp_fr;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_1238;
        fast_addr    = 32'h0000_0100;
        for (int k = 1; k <= 24; k++) begin
            tick;
            exp_fr = (k == 5 || k == 6);
            checks++;
            if (fast_ready !== exp_fr || (exp_fr && fast_data !== 32'hDE22BE44)) begin
                $display("FAIL stall_read_k%0d: got %b/%h expected %b/de22be44", k, fast_ready, fast_data, exp_fr);
                fails++;
            end
            if (refill_valid) begin
                checks++;
                if ({refill_addr, refill_data} !== {32'h1220 + 32'(4*nb), 32'hA500_0000 + 32'(nb)} ||
                    k != nb + 2 + ((nb >= 3) ? 2 : 0)) begin
                    $display("FAIL stall_beat%0d: got %h/%h at cycle %0d expected %h/%h at cycle %0d", nb,
                             refill_addr, refill_data, k, 32'h1220 + 32'(4*nb), 32'hA500_0000 + 32'(nb),
                             nb + 2 + ((nb >= 3) ? 2 : 0));
                    fails++;
                end
                $display("stall beat %0d: addr=%h cycle=%0d", nb, refill_addr, k);
                nb++;
            end
            if (refill_ready) begin
                ready_k = k;
                break;
            end
            fast_valid = (k == 4 || k == 5);
        end
        fast_valid = 1'b0;
        checks++;
        if (nb != 8 || ready_k != 12) begin
            $display("FAIL stall_complete: got %0d beats ready at %0d expected 8 beats ready at 12", nb, ready_k);
            fails++;
        end
`ifdef MEM_ARB_PERF_EN
        checks++;
        if ({refill_stall_cnt, read_conflict_cnt} !== {32'd2, 32'd2}) begin
            $display("FAIL perf_counts: got stall %0d conflict %0d expected 2 2", refill_stall_cnt, read_conflict_cnt);
            fails++;
        end
`endif
        ic_req_valid = 1'b0;
        tick;
        checks++;
        if (refill_ready !== 1'b0) begin
            $display("FAIL stall_release: got %b expected 0", refill_ready);
            fails++;
        end
    endtask

    task automatic test_wrap;
        int nb = 0;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'hFFFF_FFE4;
        for (int k = 1; k <= 20 && !refill_ready; k++) begin
            tick;
            if (refill_valid) begin
                checks++;
                if ({refill_addr, refill_data} !== {32'hFFFF_FFE0 + 32'(4*nb), 32'h5A00_0000 + 32'(nb)}) begin
                    $display("FAIL wrap_beat%0d: got %h/%h expected %h/%h", nb, refill_addr, refill_data,
                             32'hFFFF_FFE0 + 32'(4*nb), 32'h5A00_0000 + 32'(nb));
                    fails++;
                end
                $display("wrap beat %0d: addr=%h data=%h", nb, refill_addr, refill_data);
                nb++;
            end
        end
        checks++;
        if (nb != 8 || refill_ready !== 1'b1) begin
            $display("FAIL wrap_complete: got %0d beats ready %b expected 8 beats ready 1", nb, refill_ready);
            fails++;
        end
        ic_req_valid = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_burst;
        int nb = 0;
        int extra = 0;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_1234;
        for (int k = 1; k <= 20 && nb < 6; k++) begin
            tick;
            if (refill_valid) nb++;
        end
        checks++;
        if (nb != 6 || refill_addr !== 32'h0000_1234) begin
            $display("FAIL midburst_beat5: got %0d beats addr %h expected 6 beats addr 00001234", nb, refill_addr);
            fails++;
        end
        rst_n      = 1'b0;
        fast_valid = 1'b1;
        fast_addr  = 32'h0000_0100;
        #1;
        checks++;
        if (outs !== 152'd0) begin
            $display("FAIL midburst_reset_outputs: got %h expected 0", outs);
            fails++;
        end
`ifdef MEM_ARB_PERF_EN
        checks++;
        if ({refill_stall_cnt, read_conflict_cnt} !== 64'd0) begin
            $display("FAIL perf_reset: got %h expected 0", {refill_stall_cnt, read_conflict_cnt});
            fails++;
        end
`endif
        tick;
        fast_valid   = 1'b0;
        ic_req_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (refill_valid || refill_ready) extra++;
        end
        checks++;
        if (extra != 0) begin
            $display("FAIL midburst_abandon: got %0d refill cycles expected 0", extra);
            fails++;
        end
        $display("reset at beat 5: %0d refill cycles after release", extra);
        fast_valid = 1'b1;
        tick;
        fast_valid = 1'b0;
        checks++;
        if ({fast_ready, fast_data} !== {1'b1, 32'hDE22BE44}) begin
            $display("FAIL post_reset_read: got %b/%h expected 1/de22be44", fast_ready, fast_data);
            fails++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        fast_valid   = 1'b0;
        fast_addr    = 32'd0;
        wr_valid     = 1'b0;
        wr_addr      = 32'd0;
        wr_data      = 32'd0;
        wr_mask      = 4'd0;
        ic_req_valid = 1'b0;
        ic_req_addr  = 32'd0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
        mem[16'h0040] = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) begin
            mem[16'h0488 + i] = 32'hA500_0000 + 32'(i);
            mem[16'hFFF8 + i] = 32'h5A00_0000 + 32'(i);
        end

        test_reset;
        test_read;
        test_write;
        test_conflict;
        test_mask_zero;
        test_io_read;
        test_refill;
        test_refill_stall;
        test_wrap;
        test_reset_mid_burst;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
